// File: rtl/and2_gate.sv
// and2_gate: bitwise AND with registered copy, rising-edge pulse and saturating high-cycle counter
module and2_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic             all_ones,
    output logic [WIDTH-1:0] Y_q,
    output logic             rise,
    output logic [CNT_W-1:0] hi_count
);
    logic prev;
    assign Y        = A & B;
    assign all_ones = &Y;
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q      <= '0;
            prev     <= 1'b0;
            rise     <= 1'b0;
            hi_count <= '0;
        end else begin
            rise <= en & all_ones & ~prev;
            if (en) begin
                Y_q  <= Y;
                prev <= all_ones;
                if (all_ones && !(&hi_count)) hi_count <= hi_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_and2_gate.sv
// tb_and2_gate: directed-vector bench for and2_gate in 1-bit, narrow-counter and 4-bit configurations
module tb_and2_gate;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a1, b1, en1, y1, ao1, yq1, rise1;
    logic [15:0] hc1;
    logic        a3, b3, en3, y3, ao3, yq3, rise3;
    logic [2:0]  hc3;
    logic [3:0]  a4, b4, y4, yq4;
    logic        en4, ao4, rise4;
    logic [15:0] hc4;

    and2_gate #(.WIDTH(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .A(a1), .B(b1), .en(en1),
        .Y(y1), .all_ones(ao1), .Y_q(yq1), .rise(rise1), .hi_count(hc1));
    and2_gate #(.WIDTH(1), .CNT_W(3)) u3 (.clk(clk), .rst(rst), .A(a3), .B(b3), .en(en3),
        .Y(y3), .all_ones(ao3), .Y_q(yq3), .rise(rise3), .hi_count(hc3));
    and2_gate #(.WIDTH(4), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .A(a4), .B(b4), .en(en4),
        .Y(y4), .all_ones(ao4), .Y_q(yq4), .rise(rise4), .hi_count(hc4));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ab;
        logic [3:0] exp_y [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        a1 = 0; b1 = 0; en1 = 0;
        a3 = 1; b3 = 1; en3 = 0;
        a4 = 4'b1011; b4 = 4'b1110; en4 = 0;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1];
            b1 = ab[0];
            #1;
            check($sformatf("y_ab%0d", i), 32'(y1), 32'(exp_y[i]));
            check($sformatf("ao_ab%0d", i), 32'(ao1), 32'(exp_y[i]));
        end
        a1 = 0; b1 = 1'bx;
        #1;
        check("y_zero_x", 32'(y1), 32'd0);
        #1;
        check("y4_mixed", 32'(y4), 32'hA);
        check("ao4_mixed", 32'(ao4), 32'd0);

        rst = 1; a1 = 1; b1 = 1; en1 = 1;
        tick();
        tick();
        check("rst_y", 32'(y1), 32'd1);
        check("rst_ao", 32'(ao1), 32'd1);
        check("rst_yq", 32'(yq1), 32'd0);
        check("rst_rise", 32'(rise1), 32'd0);
        check("rst_hc", 32'(hc1), 32'd0);

        rst = 0;
        tick();
        check("rel_yq", 32'(yq1), 32'd1);
        check("rel_rise", 32'(rise1), 32'd1);
        check("rel_hc", 32'(hc1), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check($sformatf("run_rise%0d", i), 32'(rise1), 32'd0);
            check($sformatf("run_hc%0d", i), 32'(hc1), 32'(i));
        end

        en1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_yq%0d", i), 32'(yq1), 32'd1);
            check($sformatf("hold_hc%0d", i), 32'(hc1), 32'd5);
            check($sformatf("hold_rise%0d", i), 32'(rise1), 32'd0);
        end
        en1 = 1;
        tick();
        check("reen_hc", 32'(hc1), 32'd6);
        check("reen_rise", 32'(rise1), 32'd0);

        // A pulse between edges must not reach the registers
        #2 a1 = 0;
        #2 a1 = 1;
        tick();
        check("glitch_yq", 32'(yq1), 32'd1);
        check("glitch_hc", 32'(hc1), 32'd7);

        a1 = 0;
        tick();
        check("low_yq", 32'(yq1), 32'd0);
        check("low_hc", 32'(hc1), 32'd7);
        a1 = 1;
        tick();
        check("rerise", 32'(rise1), 32'd1);
        check("rerise_hc", 32'(hc1), 32'd8);

        rst = 1;
        tick();
        check("mid_rst_yq", 32'(yq1), 32'd0);
        check("mid_rst_rise", 32'(rise1), 32'd0);
        check("mid_rst_hc", 32'(hc1), 32'd0);

        rst = 0; en3 = 1; en4 = 1; a4 = 4'hF; b4 = 4'hF;
        #1;
        check("y4_full", 32'(y4), 32'hF);
        check("ao4_full", 32'(ao4), 32'd1);
        tick();
        check("r4_rise", 32'(rise4), 32'd1);
        check("r4_yq", 32'(yq4), 32'hF);
        check("r4_hc", 32'(hc4), 32'd1);
        check("sat_hc1", 32'(hc3), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            tick();
            check($sformatf("sat_hc%0d", i), 32'(hc3), 32'(i < 7 ? i : 7));
        end
        check("sat_rise", 32'(rise3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/and2_gate.md
Name: and2_gate

Overview:
- Bitwise two-input AND block with zero-latency combinational output Y, plus a registered copy and simple activity monitoring.
- Used as a basic logic primitive; the registered side lets downstream synchronous logic sample AND results and count how often they are asserted.
- WIDTH=1 gives the classic 2-input gate: Y=0 for inputs 00, 01 and 10, and Y=1 for input 11.

Parameters:
- WIDTH, 1, bit width of A, B, Y, Y_q.
- CNT_W, 16, width of the saturating high-cycle counter.

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- en  input  1  sample enable for registered logic.
- Y  output  WIDTH  combinational bitwise A & B.
- all_ones  output  1  combinational reduction AND of Y (equals Y when WIDTH=1).
- Y_q  output  WIDTH  registered Y.
- rise  output  1  one-cycle pulse on a 0->1 transition of sampled all_ones.
- hi_count  output  CNT_W  saturating count of enabled cycles with all_ones=1.

Behaviour:
- Combinational path:
  - Y = A & B bitwise, zero latency, independent of clk, rst and en.
  - all_ones = &Y.
  - 4-state semantics are standard: a 0 on either input forces 0 even if the other input is X/Z.
- Synchronous reset:
  - At a rising clk edge with rst=1: Y_q<=0, internal prev<=0, rise<=0, hi_count<=0.
  - Reset dominates en.
  - Combinational Y and all_ones are unaffected by reset.
- Normal cycle (rst=0, en=1), at the rising edge:
  - Y_q<=Y.
  - rise<=all_ones & ~prev.
  - prev<=all_ones.
  - If all_ones=1 and hi_count != 2^CNT_W-1, hi_count increments by 1; it saturates at all-ones and never wraps.
- Hold cycle (rst=0, en=0):
  - Y_q, prev and hi_count hold their values.
  - rise<=0, so it is never more than one cycle wide.
- Latency: Y_q, rise and hi_count reflect the inputs one clock after sampling.
- Boundary cases:
  - If all_ones stays 1 across consecutive enabled cycles, rise fires only on the first.
  - After reset, prev=0, so all_ones=1 on the first enabled cycle produces rise.
  - Reset asserted mid-operation clears all registers at the next edge, regardless of inputs.
  - Inputs changing between edges affect only Y and all_ones, never the registers.

Test Plan:
- WIDTH=1: drive A/B = 0/0, 0/1, 1/0, 1/1 with a settle delay after each -> Y = 0, 0, 0, 1 and all_ones matches Y; no clock is needed.
- Reset: rst=1 for 2 cycles with A=B=1, en=1 -> Y=1 but Y_q=0, rise=0, hi_count=0; release rst -> next edge Y_q=1, rise=1, hi_count=1.
- Hold A=B=1, en=1 for 5 cycles after reset -> rise high only in the first cycle, hi_count=5.
- en=0 for 3 cycles with A=B=1 -> Y_q and hi_count unchanged, rise=0; re-enable -> hi_count resumes incrementing, no rise because prev=1.
- CNT_W=3, A=B=1, en=1 for 10 cycles -> hi_count saturates at 7.
- WIDTH=4: A=4'b1011, B=4'b1110 -> Y=4'b1010, all_ones=0; A=B=4'hF -> Y=4'hF, all_ones=1, and the next enabled edge gives rise=1.
